pipe_adder: RTL and testbench

Parameterised, pipelined successor to the single-bit full adder: adds two WIDTH-bit operands plus carry-in.
- Carry ripples through STAGES register stages, one WIDTH/STAGES-bit chunk per stage.
- Valid/ready handshake on both sides; full-throughput streaming with backpressure.
- Building block for wide datapath arithmetic where a single-cycle WIDTH-bit ripple misses timing.

---
 rtl/pipe_adder.sv | 154 +++++++++++++++
 tb/tb_pipe_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple adder: one CW-bit chunk per register stage, valid/ready on both sides.
// Optional signed-overflow output enabled with `define PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_adder: STAGES must be at least 1");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             stall;
    logic             valid_stage [STAGES];
    logic             carry_stage [STAGES];
    logic [WIDTH-1:0] a_stage     [STAGES];
    logic [WIDTH-1:0] b_stage     [STAGES];
    logic [WIDTH-1:0] sum_stage   [STAGES];

    assign stall     = valid_stage[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_stage[STAGES-1];
    assign sum       = sum_stage[STAGES-1];
    assign c_out     = carry_stage[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vin;
        logic             cin;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [CW:0]      chunk;
        logic             valid_d, valid_q;
        logic             carry_d, carry_q;
        logic [WIDTH-1:0] sum_d, sum_q;

        if (k == 0) begin : g_head
            always_comb begin
                vin    = in_valid;
                cin    = c_in;
                a_in   = a;
                b_in   = b;
                sum_in = '0;
            end
        end else begin : g_tail
            always_comb begin
                vin    = valid_stage[k-1];
                cin    = carry_stage[k-1];
                a_in   = a_stage[k-1];
                b_in   = b_stage[k-1];
                sum_in = sum_stage[k-1];
            end
        end

        always_comb begin
            chunk   = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, cin};
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (!stall) begin
                valid_d              = vin;
                carry_d              = chunk[CW];
                sum_d                = sum_in;
                sum_d[k*CW +: CW]    = chunk[CW-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        assign valid_stage[k] = valid_q;
        assign carry_stage[k] = carry_q;
        assign sum_stage[k]   = sum_q;

        // Operand skew registers only exist where a later stage still needs upper chunks.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

            always_comb begin
                a_d = stall ? a_q : a_in;
                b_d = stall ? b_q : b_in;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_stage[k] = a_q;
            assign b_stage[k] = b_q;
        end else begin : g_noskew
            assign a_stage[k] = a_in;
            assign b_stage[k] = b_in;
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d, ovf_q;

            // Top sum bit is the MSB of the final chunk computed here.
            always_comb begin
                ovf_d = ovf_q;
                if (!stall) begin
                    ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (chunk[CW-1] != a_in[WIDTH-1]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf = ovf_q;
        end
`endif
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors plus random streaming with
// backpressure, checked against a slot-level behavioural model of the pipeline.
module tb_pipe_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf_o;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPE_ADDER_OVF_EN
        .ovf       (ovf_o),
`endif
        .c_out     (c_out)
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: S slots, each holding the full-width expected result of one accepted operand set.
    logic         exp_v [S];
    logic [W:0]   exp_r [S];
    logic         exp_o [S];
    logic         acc;
    logic [W+1:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < S; i++) begin
            exp_v[i] = 1'b0;
            exp_r[i] = '0;
            exp_o[i] = 1'b0;
        end
        got.delete();
    endtask

    // One clock: compare at negedge, update model, advance past posedge.
    task automatic step();
        logic       st;
        logic [W:0] r;
        @(negedge clk);
        st = exp_v[S-1] && !out_ready;
        chk("in_ready", 32'(in_ready), 32'(!st));
        chk("out_valid", 32'(out_valid), 32'(exp_v[S-1]));
        if (exp_v[S-1]) begin
            chk("sum", 32'(sum), 32'(exp_r[S-1][W-1:0]));
            chk("c_out", 32'(c_out), 32'(exp_r[S-1][W]));
`ifdef PIPE_ADDER_OVF_EN
            chk("ovf", 32'(ovf_o), 32'(exp_o[S-1]));
`endif
        end
        if (out_valid && out_ready) got.push_back({ovf_o, c_out, sum});
        acc = in_valid && !st;
        if (!st) begin
            for (int i = S - 1; i > 0; i--) begin
                exp_v[i] = exp_v[i-1];
                exp_r[i] = exp_r[i-1];
                exp_o[i] = exp_o[i-1];
            end
            r        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
            exp_v[0] = in_valid;
            exp_r[0] = r;
            exp_o[0] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int n;
        a = va; b = vb; c_in = vc; in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (S + 2) step();
    endtask

    task automatic chk_got(input int idx, input logic [W:0] e, input logic eo);
        if (idx >= got.size()) begin
            chk("got_missing", 32'(got.size()), 32'(idx + 1));
        end else begin
            chk("got_result", 32'(got[idx][W:0]), 32'(e));
`ifdef PIPE_ADDER_OVF_EN
            chk("got_ovf", 32'(got[idx][W+1]), 32'(eo));
`endif
        end
    endtask

    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic         tc [8];
    logic [W:0]   te [8];

    initial begin
        int lat;
        int pend;
        logic [W:0] ref_q [$];
        model_clear();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        rst_n = 1'b1;

        // Latency of a single transfer
        send(16'h0003, 16'h0004, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(S));
        drain();
        chk_got(0, 17'h0_0008, 1'b0);

        // Carry through every chunk, then a mixed carry pattern
        got.delete();
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h00FF, 16'h0F01, 1'b1);
        drain();
        chk("got_count_2", 32'(got.size()), 32'd2);
        chk_got(0, 17'h1_0000, 1'b0);
        chk_got(1, 17'h0_1001, 1'b0);

        // Back-to-back stream of 8; model checks out_valid every cycle (no gaps)
        ta = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000, 16'h00F0, 16'hAAAA, 16'h7FFF, 16'h0000};
        tb = '{16'h0002, 16'hFFFF, 16'h4321, 16'h8000, 16'h0010, 16'h5555, 16'h7FFF, 16'h0000};
        tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        te = '{17'h0_0003, 17'h1_FFFF, 17'h0_5555, 17'h1_0000, 17'h0_0101, 17'h1_0000, 17'h0_FFFE, 17'h0_0001};
        got.delete();
        for (int i = 0; i < 8; i++) send(ta[i], tb[i], tc[i]);
        drain();
        chk("got_count_8", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_got(i, te[i], 1'b0 ^ ((ta[i][W-1] == tb[i][W-1]) && (te[i][W-1] != ta[i][W-1])));

        // Full pipeline, 3-cycle stall, then release
        got.delete();
        for (int i = 0; i < S; i++) send(ta[i], tb[i], tc[i]);
        out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("stall_no_accept", 32'(acc), 32'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("got_count_stall", 32'(got.size()), 32'(S));
        for (int i = 0; i < S; i++) chk_got(i, te[i], (ta[i][W-1] == tb[i][W-1]) && (te[i][W-1] != ta[i][W-1]));

        // Random bubbles and backpressure; upstream holds operands until accepted
        got.delete();
        ref_q.delete();
        pend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin a = '1; b = '1; end
                pend = 1;
            end
            in_valid  = pend[0];
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            if (acc) begin
                ref_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in});
                pend = 0;
            end
        end
        in_valid = 1'b0;
        drain();
        chk("rand_count", 32'(got.size()), 32'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < got.size(); i++) begin
            if (got[i][W:0] !== ref_q[i]) chk("rand_order", 32'(got[i][W:0]), 32'(ref_q[i]));
        end

        // Reset with results in flight
        out_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0);
        send(16'h0300, 16'h0400, 1'b0);
        send(16'h0500, 16'h0600, 1'b0);
        repeat (S) step();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0ABC, 16'h0001, 1'b1);
        drain();
        chk("post_reset_count", 32'(got.size()), 32'd1);
        chk_got(0, 17'h0_0ABE, 1'b0);

`ifdef PIPE_ADDER_OVF_EN
        got.delete();
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0);
        send(16'h1234, 16'h0001, 1'b0);
        drain();
        chk_got(0, 17'h0_8000, 1'b1);
        chk_got(1, 17'h1_7FFF, 1'b1);
        chk_got(2, 17'h0_1235, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
